ysyx_22040383_div_seq: RTL and testbench
========================================

YSYX_22040383_DIV_SEQ -- requirements
Module: ysyx_22040383_div_seq

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port flush, input, 1 bit: abort the operation in flight.
REQ-004 SHALL have port in_valid, input, 1 bit: the request operands are valid.
REQ-005 SHALL have port in_ready, output, 1 bit: the sequencer can accept a request.
REQ-006 SHALL have port dividend, input, `ysyx_22040383_width (64 bits): the dividend operand.
REQ-007 SHALL have port divisor, input, `ysyx_22040383_width (64 bits): the divisor operand.
REQ-008 SHALL have port div_signed, input, 1 bit: 1 = signed divide, 0 = unsigned divide.
REQ-009 SHALL have port word_op, input, 1 bit: 1 = 32-bit W-form operation using operand bits [31:0].
REQ-010 SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-011 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-012 SHALL have port quotient, output, 64 bits: the quotient result.
REQ-013 SHALL have port remainder, output, 64 bits: the remainder result.

Function
REQ-014 SHALL implement FSM states IDLE, CALC and DONE; in_ready SHALL be 1 only in IDLE.
REQ-015 In IDLE, on in_valid&&in_ready&&!flush, SHALL capture operands, div_signed and word_op, then go to CALC with iteration counter 0.
REQ-016 SHALL use N=64 iterations, or N=32 when word_op=1; operands SHALL be taken as bits [31:0], sign-extended when div_signed=1 and zero-extended otherwise.
REQ-017 Signed operation SHALL divide magnitudes, then negate the quotient when operand signs differ, and give the remainder the sign of the dividend.
REQ-018 Each CALC cycle SHALL perform one restoring step, a 1-bit shift plus a trial subtract of the divisor magnitude through the ALU datapath (sub=1); the quotient bit SHALL be the carry-out.
REQ-019 After iteration N-1, the FSM SHALL enter DONE with sign-corrected results registered; out_valid SHALL first be high N edges after the accepting edge.
REQ-020 In DONE, out_valid SHALL be 1 and quotient/remainder SHALL hold stable until out_valid&&out_ready, then the FSM SHALL return to IDLE.
REQ-021 A new request SHALL NOT be accepted in the same cycle as result retirement; the minimum request spacing is N+2 cycles.
REQ-022 Divide-by-zero SHALL force quotient = all ones and remainder = dividend.
REQ-023 Signed overflow (most negative value / -1) SHALL force quotient = dividend and remainder = 0.
REQ-024 With word_op=1, both results SHALL be sign-extended from bit 31 of the 32-bit result, including for the REQ-022/023 forced values.
REQ-025 flush SHALL take priority over every event: next state IDLE, out_valid 0, in-flight result discarded, regardless of state or out_ready.

Reset
REQ-026 While rst_n=0, SHALL hold state IDLE, out_valid=0, quotient=0, remainder=0, counter=0 and in_ready=1.
REQ-027 Reset asserted mid-CALC or mid-DONE SHALL immediately discard the operation, with no result ever presented.

Configuration
REQ-028 With macro YSYX_22040383_DIV_EARLY_OUT_EN defined, divide-by-zero and signed overflow SHALL skip CALC and go directly to DONE, so out_valid is high one edge after acceptance.
REQ-029 With YSYX_22040383_DIV_EARLY_OUT_EN undefined, divide-by-zero and signed overflow SHALL take the full N iterations and produce the forced results of REQ-022/023.

Structure
REQ-030 FSM state encodings and the iteration counts 64/32 SHALL be defined as constants in para.v alongside `ysyx_22040383_width.
REQ-031 The trial subtract SHALL use one instance of the existing ysyx_22040383_exu (sub=1, word_op=0); the FSM, counter and shift registers SHALL be local to this module.

Verification
REQ-032 Unsigned case: 100/7, word_op=0 -> quotient 14, remainder 2, out_valid exactly 64 edges after acceptance.
REQ-033 Signed W-form case: -7/2, div_signed=1, word_op=1 -> quotient 0xFFFFFFFFFFFFFFFD, remainder 0xFFFFFFFFFFFFFFFF, latency 32 edges.
REQ-034 Divide-by-zero: 5/0 -> quotient 0xFFFFFFFFFFFFFFFF, remainder 5; latency 1 edge with YSYX_22040383_DIV_EARLY_OUT_EN defined, 64 edges without.
REQ-035 Signed overflow: 0x8000000000000000 / -1, signed -> quotient 0x8000000000000000, remainder 0.
REQ-036 Backpressure: out_ready held 0 for 10 cycles in DONE -> results stable and in_ready=0 throughout; retirement on out_ready=1, in_ready=1 the next cycle.
REQ-037 Flush and reset: flush at CALC iteration 20 -> IDLE next cycle, no out_valid; rst_n pulsed low in DONE -> out_valid drops asynchronously.

Source files
------------

// File: rtl/ysyx_22040383_div_seq_pkg.sv
// Shared width, iteration counts, FSM encoding and sign/result helpers for the sequential divider.
// Feature macro consumed by the top: YSYX_22040383_DIV_EARLY_OUT_EN.
`ifndef YSYX_22040383_WIDTH
`define YSYX_22040383_WIDTH 64
`endif

package ysyx_22040383_div_seq_pkg;

    localparam int XLEN   = `YSYX_22040383_WIDTH;
    localparam int ITER_D = 64;
    localparam int ITER_W = 32;
    localparam int CNT_W  = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

    typedef struct packed {
        logic [XLEN-1:0] quo;
        logic [XLEN-1:0] rem;
    } div_res_t;

    function automatic logic [XLEN-1:0] sext_w(input logic [XLEN-1:0] v);
        return {{(XLEN-32){v[31]}}, v[31:0]};
    endfunction

    function automatic logic [XLEN-1:0] extend_op(input logic [XLEN-1:0] v, input logic sgn, input logic word);
        if (!word) return v;
        return sgn ? sext_w(v) : {{(XLEN-32){1'b0}}, v[31:0]};
    endfunction

    function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v, input logic sgn);
        return (sgn && v[XLEN-1]) ? -v : v;
    endfunction

    // Operands arrive already extended, so the W-form minimum is the sign-extended 0x80000000.
    function automatic logic is_overflow(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                         input logic sgn, input logic word);
        logic [XLEN-1:0] min_val;
        min_val = word ? {{(XLEN-31){1'b1}}, {31{1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
        return sgn && (b == '1) && (a == min_val);
    endfunction

    function automatic logic is_special(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                        input logic sgn, input logic word);
        return (b == '0) || is_overflow(a, b, sgn, word);
    endfunction

    function automatic div_res_t finalize(input logic [XLEN-1:0] qmag, input logic [XLEN-1:0] rmag,
                                          input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                          input logic sgn, input logic word);
        div_res_t res;
        logic     a_neg;
        logic     b_neg;
        a_neg   = sgn && a[XLEN-1];
        b_neg   = sgn && b[XLEN-1];
        res.quo = (a_neg != b_neg) ? -qmag : qmag;
        res.rem = a_neg ? -rmag : rmag;
        if (b == '0) begin
            res.quo = '1;
            res.rem = a;
        end else if (is_overflow(a, b, sgn, word)) begin
            res.quo = a;
            res.rem = '0;
        end
        if (word) begin
            res.quo = sext_w(res.quo);
            res.rem = sext_w(res.rem);
        end
        return res;
    endfunction

endpackage

// File: rtl/ysyx_22040383_div_seq_if.sv
// Request/response handshake bundle of the sequential divider; slave = divider, master = requester.
interface ysyx_22040383_div_seq_if;
    import ysyx_22040383_div_seq_pkg::*;

    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] dividend;
    logic [XLEN-1:0] divisor;
    logic            div_signed;
    logic            word_op;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] quotient;
    logic [XLEN-1:0] remainder;

    modport master (
        output flush, in_valid, dividend, divisor, div_signed, word_op, out_ready,
        input  in_ready, out_valid, quotient, remainder
    );

    modport slave (
        input  flush, in_valid, dividend, divisor, div_signed, word_op, out_ready,
        output in_ready, out_valid, quotient, remainder
    );
endinterface

// File: rtl/ysyx_22040383_div_seq_exu.sv
// Adder/subtractor datapath; carry is the carry-out of src1 + ~src2 + 1 when sub=1 (set when src1 >= src2).
module ysyx_22040383_exu
    import ysyx_22040383_div_seq_pkg::*;
(
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic            sub,
    input  logic            word_op,
    output logic [XLEN-1:0] result,
    output logic            carry
);
    logic [XLEN:0] sum;

    assign sum    = {1'b0, src1} + {1'b0, (sub ? ~src2 : src2)} + {{XLEN{1'b0}}, sub};
    assign carry  = sum[XLEN];
    assign result = word_op ? sext_w(sum[XLEN-1:0]) : sum[XLEN-1:0];
endmodule

// File: rtl/ysyx_22040383_div_seq.sv
// Sequential restoring divider: one quotient bit per CALC cycle through the shared EXU subtractor.
// Build option YSYX_22040383_DIV_EARLY_OUT_EN retires divide-by-zero and signed overflow right after acceptance.
module ysyx_22040383_div_seq
    import ysyx_22040383_div_seq_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    ysyx_22040383_div_seq_if.slave bus
);
    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  a_q, a_d, b_q, b_d, bmag_q, bmag_d;
    logic [XLEN-1:0]  rem_q, rem_d, quo_q, quo_d;
    logic             sgn_q, sgn_d, word_q, word_d;
    div_res_t         res_q, res_d;

    logic [XLEN-1:0]  a_ext, b_ext, a_mag, shifted, diff, step_quo, step_rem;
    logic             carry, last_iter;

    assign a_ext     = extend_op(bus.dividend, bus.div_signed, bus.word_op);
    assign b_ext     = extend_op(bus.divisor, bus.div_signed, bus.word_op);
    assign a_mag     = magnitude(a_ext, bus.div_signed);
    assign shifted   = {rem_q[XLEN-2:0], quo_q[XLEN-1]};
    assign step_quo  = {quo_q[XLEN-2:0], carry};
    assign step_rem  = carry ? diff : shifted;
    assign last_iter = (cnt_q == CNT_W'(word_q ? ITER_W - 1 : ITER_D - 1));

    ysyx_22040383_exu u_exu (
        .src1    (shifted),
        .src2    (bmag_q),
        .sub     (1'b1),
        .word_op (1'b0),
        .result  (diff),
        .carry   (carry)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        bmag_d  = bmag_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        sgn_d   = sgn_q;
        word_d  = word_q;
        res_d   = res_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (bus.in_valid) begin
                    a_d     = a_ext;
                    b_d     = b_ext;
                    bmag_d  = magnitude(b_ext, bus.div_signed);
                    sgn_d   = bus.div_signed;
                    word_d  = bus.word_op;
                    rem_d   = '0;
                    // W-form dividends sit in the top half so 32 shifts leave the quotient in [31:0].
                    quo_d   = bus.word_op ? {a_mag[31:0], {(XLEN-32){1'b0}}} : a_mag;
                    state_d = CALC;
`ifdef YSYX_22040383_DIV_EARLY_OUT_EN
                    if (is_special(a_ext, b_ext, bus.div_signed, bus.word_op)) begin
                        res_d   = finalize('0, '0, a_ext, b_ext, bus.div_signed, bus.word_op);
                        state_d = DONE;
                    end
`endif
                end
            end
            CALC: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q + CNT_W'(1);
                if (last_iter) begin
                    res_d   = finalize(step_quo, step_rem, a_q, b_q, sgn_q, word_q);
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (bus.flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            bmag_q  <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            sgn_q   <= 1'b0;
            word_q  <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            bmag_q  <= bmag_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            sgn_q   <= sgn_d;
            word_q  <= word_d;
            res_q   <= res_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.quotient  = res_q.quo;
    assign bus.remainder = res_q.rem;
endmodule

// File: tb/tb_ysyx_22040383_div_seq.sv
// Directed self-checking bench for ysyx_22040383_div_seq: results, latency, backpressure, flush and reset.
`timescale 1ns/1ps
module tb_ysyx_22040383_div_seq;

`ifdef YSYX_22040383_DIV_EARLY_OUT_EN
    localparam int SPECIAL_LAT_D = 1;
    localparam int SPECIAL_LAT_W = 1;
`else
    localparam int SPECIAL_LAT_D = 64;
    localparam int SPECIAL_LAT_W = 32;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   checkCount = 0;
    int   errorCount = 0;
    int   validSeen;

    ysyx_22040383_div_seq_if bus();

    ysyx_22040383_div_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [63:0] a, input logic [63:0] b, input logic sgn, input logic word);
        int guard = 0;
        @(negedge clk);
        bus.dividend   = a;
        bus.divisor    = b;
        bus.div_signed = sgn;
        bus.word_op    = word;
        bus.in_valid   = 1'b1;
        while (!bus.in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("accept_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic waitResult(input string tag, input int expLat);
        int lat = 0;
        while (lat < 200) begin
            @(posedge clk);
            lat++;
            #1;
            if (bus.out_valid) break;
        end
        checkOutput({tag, "_latency"}, 64'(lat), 64'(expLat));
    endtask

    task automatic runCase(input string tag, input logic [63:0] a, input logic [63:0] b,
                           input logic sgn, input logic word, input logic [63:0] expQ,
                           input logic [63:0] expR, input int expLat, input int holdCycles);
        applyStimulus(a, b, sgn, word);
        waitResult(tag, expLat);
        checkOutput({tag, "_quotient"}, bus.quotient, expQ);
        checkOutput({tag, "_remainder"}, bus.remainder, expR);
        for (int i = 0; i < holdCycles; i++) begin
            @(posedge clk);
            #1;
            checkOutput({tag, "_hold_valid"}, 64'(bus.out_valid), 64'd1);
            checkOutput({tag, "_hold_quotient"}, bus.quotient, expQ);
            checkOutput({tag, "_hold_remainder"}, bus.remainder, expR);
            checkOutput({tag, "_hold_in_ready"}, 64'(bus.in_ready), 64'd0);
        end
        // A new request presented during retirement must not be taken on that edge.
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.dividend  = 64'd9;
        bus.divisor   = 64'd3;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        checkOutput({tag, "_retire_valid"}, 64'(bus.out_valid), 64'd0);
        checkOutput({tag, "_retire_in_ready"}, 64'(bus.in_ready), 64'd1);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n          = 1'b0;
        bus.flush      = 1'b0;
        bus.in_valid   = 1'b0;
        bus.dividend   = '0;
        bus.divisor    = '0;
        bus.div_signed = 1'b0;
        bus.word_op    = 1'b0;
        bus.out_ready  = 1'b0;
        #12;
        checkOutput("reset_in_ready", 64'(bus.in_ready), 64'd1);
        checkOutput("reset_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("reset_quotient", bus.quotient, 64'd0);
        checkOutput("reset_remainder", bus.remainder, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        runCase("udiv_100_7", 64'd100, 64'd7, 1'b0, 1'b0, 64'd14, 64'd2, 64, 10);
        runCase("sdivw_m7_2", 64'hFFFFFFFFFFFFFFF9, 64'd2, 1'b1, 1'b1,
                64'hFFFFFFFFFFFFFFFD, 64'hFFFFFFFFFFFFFFFF, 32, 0);
        runCase("udiv_by_zero", 64'd5, 64'd0, 1'b0, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'd5, SPECIAL_LAT_D, 0);
        runCase("sdiv_overflow", 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 1'b1, 1'b0,
                64'h8000000000000000, 64'd0, SPECIAL_LAT_D, 0);
        runCase("sdiv_m100_7", 64'hFFFFFFFFFFFFFF9C, 64'd7, 1'b1, 1'b0,
                64'hFFFFFFFFFFFFFFF2, 64'hFFFFFFFFFFFFFFFE, 64, 0);
        runCase("sdiv_100_m7", 64'd100, 64'hFFFFFFFFFFFFFFF9, 1'b1, 1'b0,
                64'hFFFFFFFFFFFFFFF2, 64'd2, 64, 0);
        runCase("udivw_ignore_upper", 64'h12345678FFFFFFFF, 64'hABCD000000000001, 1'b0, 1'b1,
                64'hFFFFFFFFFFFFFFFF, 64'd0, 32, 0);
        runCase("udiv_big_divisor", 64'hFFFFFFFFFFFFFFFF, 64'hC000000000000000, 1'b0, 1'b0,
                64'd1, 64'h3FFFFFFFFFFFFFFF, 64, 0);
        runCase("sdivw_by_zero", 64'hDEADBEEF80000005, 64'hFFFFFFFF00000000, 1'b1, 1'b1,
                64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFF80000005, SPECIAL_LAT_W, 0);
        runCase("sdivw_overflow", 64'h0000000080000000, 64'h00000000FFFFFFFF, 1'b1, 1'b1,
                64'hFFFFFFFF80000000, 64'd0, SPECIAL_LAT_W, 0);

        // Flush while CALC is at iteration 20.
        applyStimulus(64'd100, 64'd7, 1'b0, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        checkOutput("flush_in_ready", 64'(bus.in_ready), 64'd1);
        checkOutput("flush_out_valid", 64'(bus.out_valid), 64'd0);
        validSeen = 0;
        repeat (80) begin
            @(negedge clk);
            if (bus.out_valid) validSeen++;
        end
        checkOutput("flush_no_result", 64'(validSeen), 64'd0);

        // Reset pulse while a result waits in DONE.
        applyStimulus(64'd100, 64'd7, 1'b0, 1'b0);
        waitResult("reset_in_done", 64);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_done_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("rst_done_in_ready", 64'(bus.in_ready), 64'd1);
        checkOutput("rst_done_quotient", bus.quotient, 64'd0);
        checkOutput("rst_done_remainder", bus.remainder, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        validSeen = 0;
        repeat (80) begin
            @(negedge clk);
            if (bus.out_valid) validSeen++;
        end
        checkOutput("rst_no_result", 64'(validSeen), 64'd0);

        runCase("udiv_after_reset", 64'd1000, 64'd10, 1'b0, 1'b0, 64'd100, 64'd0, 64, 0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
